// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART command scheduler.
package uart_pkg;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_CMD_WIDTH   = 16;
    localparam int unsigned DEF_READ_WIDTH  = 8;
    localparam int unsigned DEF_TIMEOUT_CYC = 100000;

    // Command bit that marks a read, for the default command width.
    localparam int unsigned CMD_READ_BIT = DEF_CMD_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SEND     = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } state_t;

endpackage

// File: rtl/uart_cmd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, with wrap-around.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          vld
);

    // Scan ptr+1 .. ptr+N (mod N); the first pending requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int k = 1; k <= int'(N); k++) begin
            int j;
            j = (int'(ptr) + k) % int'(N);
            if (!vld && req[j]) begin
                gnt[j] = 1'b1;
                idx    = IW'(j);
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_sched.sv
// Shares one UART command/response channel among NUM_REQ requesters.
module uart_cmd_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned CMD_WIDTH   = DEF_CMD_WIDTH,
    parameter int unsigned READ_WIDTH  = DEF_READ_WIDTH,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_vld,
    input  logic [NUM_REQ*CMD_WIDTH-1:0]   req_cmd,
    output logic [NUM_REQ-1:0]             req_rdy,
    output logic [NUM_REQ-1:0]             rsp_vld,
    output logic [READ_WIDTH-1:0]          rsp_data,
    output logic                           rsp_err,
    output logic                           rsp_perr,
    output logic                           busy,
    output logic [CMD_WIDTH-1:0]           uart_cmd,
    output logic                           uart_cmd_vld,
    input  logic                           uart_cmd_rdy,
    input  logic                           uart_read_rdy,
    input  logic [READ_WIDTH:0]            uart_read_data
);

    localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned RD_BIT = CMD_WIDTH - 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [NUM_REQ-1:0]     arb_gnt;
    logic [IW-1:0]          arb_idx;
    logic                   arb_vld;
    logic [IW-1:0]          ptr;
    logic [IW-1:0]          gnt_idx;
    logic [CMD_WIDTH-1:0]   cmd_q;
    logic [CMD_WIDTH-1:0]   sel_cmd;
    logic [TW-1:0]          timer;
    logic                   timeout;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_vld),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .vld (arb_vld)
    );

    assign timeout = (timer == TW'(TIMEOUT_CYC - 1));

    // Pick the winning requester's command word out of the packed bus.
    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (arb_idx == IW'(i)) begin
                sel_cmd = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a read response beats a timeout in the same cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (arb_vld) state_nxt = SEND;
            SEND:     if (uart_cmd_rdy) state_nxt = cmd_q[RD_BIT] ? WAIT_RSP : IDLE;
            WAIT_RSP: if (uart_read_rdy || timeout) state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Command/grant latches, response capture and the response timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= IW'(NUM_REQ - 1);
            gnt_idx  <= '0;
            cmd_q    <= '0;
            timer    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            rsp_perr <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arb_vld) begin
                        cmd_q   <= sel_cmd;
                        gnt_idx <= arb_idx;
                        ptr     <= arb_idx;
                    end
                end
                SEND: begin
                    if (uart_cmd_rdy) timer <= '0;
                end
                WAIT_RSP: begin
                    if (!timeout) timer <= timer + TW'(1);
                    if (uart_read_rdy) begin
                        rsp_data <= uart_read_data[READ_WIDTH-1:0];
                        rsp_perr <= uart_read_data[READ_WIDTH];
                        rsp_err  <= 1'b0;
                    end else if (timeout) begin
                        rsp_data <= '0;
                        rsp_perr <= 1'b0;
                        rsp_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state flops; req_rdy is the same-cycle accept.
    assign req_rdy      = (state == IDLE && !rst) ? arb_gnt : '0;
    assign rsp_vld      = (state == RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign busy         = (state != IDLE);
    assign uart_cmd_vld = (state == SEND);
    assign uart_cmd     = cmd_q;

endmodule

// File: tb/tb_uart_cmd_sched.sv
// Directed self-checking bench for uart_cmd_sched.
module tb_uart_cmd_sched;

    localparam int unsigned NR = 4;
    localparam int unsigned CW = 16;
    localparam int unsigned RW = 8;
    localparam int unsigned TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_vld;
    logic [NR*CW-1:0]  req_cmd;
    logic [NR-1:0]     req_rdy;
    logic [NR-1:0]     rsp_vld;
    logic [RW-1:0]     rsp_data;
    logic              rsp_err;
    logic              rsp_perr;
    logic              busy;
    logic [CW-1:0]     uart_cmd;
    logic              uart_cmd_vld;
    logic              uart_cmd_rdy;
    logic              uart_read_rdy;
    logic [RW:0]       uart_read_data;

    int n_tests = 0;
    int n_fail  = 0;

    uart_cmd_sched #(
        .NUM_REQ(NR), .CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_vld        (req_vld),
        .req_cmd        (req_cmd),
        .req_rdy        (req_rdy),
        .rsp_vld        (rsp_vld),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .rsp_perr       (rsp_perr),
        .busy           (busy),
        .uart_cmd       (uart_cmd),
        .uart_cmd_vld   (uart_cmd_vld),
        .uart_cmd_rdy   (uart_cmd_rdy),
        .uart_read_rdy  (uart_read_rdy),
        .uart_read_data (uart_read_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        logic [15:0] rr_cmd [4];
        int          rr_exp [5];
        rr_cmd = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        rr_exp = '{0, 1, 2, 3, 0};

        // Reset with a pending request: nothing may be accepted.
        rst = 1'b1;
        req_vld = 4'b0001;
        req_cmd = '0;
        uart_cmd_rdy = 1'b0;
        uart_read_rdy = 1'b0;
        uart_read_data = '0;
        repeat (3) tick();
        chk("rst_req_rdy", 32'(req_rdy), 32'h0);
        chk("rst_rsp_vld", 32'(rsp_vld), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_perr", 32'(rsp_perr), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_uart_cmd", 32'(uart_cmd), 32'h0);
        chk("rst_uart_cmd_vld", 32'(uart_cmd_vld), 32'h0);
        req_vld = '0;
        rst = 1'b0;
        tick();

        // Single write from requester 1, UART stalls for 5 cycles.
        req_vld = 4'b0010;
        req_cmd[1*CW +: CW] = 16'h1234;
        settle();
        chk("wr_req_rdy", 32'(req_rdy), 32'h2);
        tick();
        req_vld = '0;
        for (int i = 0; i < 5; i++) begin
            chk("wr_hold_vld", 32'(uart_cmd_vld), 32'h1);
            chk("wr_hold_cmd", 32'(uart_cmd), 32'h1234);
            chk("wr_hold_rsp", 32'(rsp_vld), 32'h0);
            tick();
        end
        uart_cmd_rdy = 1'b1;
        settle();
        chk("wr_hs_vld", 32'(uart_cmd_vld), 32'h1);
        tick();
        uart_cmd_rdy = 1'b0;
        chk("wr_idle_busy", 32'(busy), 32'h0);
        chk("wr_idle_vld", 32'(uart_cmd_vld), 32'h0);
        chk("wr_no_rsp", 32'(rsp_vld), 32'h0);

        // Read from requester 2 with parity error set in the response.
        req_vld = 4'b0100;
        req_cmd[2*CW +: CW] = 16'h8055;
        settle();
        chk("rd_req_rdy", 32'(req_rdy), 32'h4);
        tick();
        req_vld = '0;
        uart_cmd_rdy = 1'b1;
        chk("rd_uart_cmd", 32'(uart_cmd), 32'h8055);
        tick();
        uart_cmd_rdy = 1'b0;
        chk("rd_wait_busy", 32'(busy), 32'h1);
        tick();
        tick();
        uart_read_rdy = 1'b1;
        uart_read_data = 9'h1A5;
        tick();
        uart_read_rdy = 1'b0;
        uart_read_data = '0;
        chk("rd_rsp_vld", 32'(rsp_vld), 32'h4);
        chk("rd_rsp_data", 32'(rsp_data), 32'hA5);
        chk("rd_rsp_perr", 32'(rsp_perr), 32'h1);
        chk("rd_rsp_err", 32'(rsp_err), 32'h0);
        tick();
        chk("rd_rsp_one_cyc", 32'(rsp_vld), 32'h0);
        chk("rd_idle_busy", 32'(busy), 32'h0);
        chk("rd_data_hold", 32'(rsp_data), 32'hA5);

        // Round-robin from reset: all requesters write, UART always ready.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) req_cmd[i*CW +: CW] = rr_cmd[i];
        req_vld = 4'b1111;
        uart_cmd_rdy = 1'b1;
        for (int g = 0; g < 5; g++) begin
            settle();
            chk("rr_grant", 32'(req_rdy), 32'(4'b0001 << rr_exp[g]));
            tick();
            chk("rr_send_rdy", 32'(req_rdy), 32'h0);
            chk("rr_send_cmd", 32'(uart_cmd), 32'(rr_cmd[rr_exp[g]]));
            chk("rr_send_vld", 32'(uart_cmd_vld), 32'h1);
            tick();
        end
        req_vld = '0;
        uart_cmd_rdy = 1'b0;
        chk("rr_end_busy", 32'(busy), 32'h0);

        // Timeout on a read from requester 3.
        req_vld = 4'b1000;
        req_cmd[3*CW +: CW] = 16'h8003;
        settle();
        chk("to_req_rdy", 32'(req_rdy), 32'h8);
        tick();
        req_vld = '0;
        uart_cmd_rdy = 1'b1;
        tick();
        uart_cmd_rdy = 1'b0;
        for (int i = 0; i < int'(TO); i++) begin
            chk("to_wait_no_rsp", 32'(rsp_vld), 32'h0);
            tick();
        end
        chk("to_rsp_vld", 32'(rsp_vld), 32'h8);
        chk("to_rsp_err", 32'(rsp_err), 32'h1);
        chk("to_rsp_data", 32'(rsp_data), 32'h0);
        chk("to_rsp_perr", 32'(rsp_perr), 32'h0);
        tick();
        chk("to_idle_busy", 32'(busy), 32'h0);

        // Data arriving in the timeout cycle wins.
        req_vld = 4'b1000;
        settle();
        chk("tr_req_rdy", 32'(req_rdy), 32'h8);
        tick();
        req_vld = '0;
        uart_cmd_rdy = 1'b1;
        tick();
        uart_cmd_rdy = 1'b0;
        repeat (TO - 1) tick();
        chk("tr_pre_rsp", 32'(rsp_vld), 32'h0);
        uart_read_rdy = 1'b1;
        uart_read_data = 9'h042;
        tick();
        uart_read_rdy = 1'b0;
        uart_read_data = '0;
        chk("tr_rsp_vld", 32'(rsp_vld), 32'h8);
        chk("tr_rsp_err", 32'(rsp_err), 32'h0);
        chk("tr_rsp_data", 32'(rsp_data), 32'h42);
        chk("tr_rsp_perr", 32'(rsp_perr), 32'h0);
        tick();

        // Read from requester 0, then reset during WAIT_RSP.
        req_vld = 4'b0001;
        req_cmd[0*CW +: CW] = 16'h8000;
        settle();
        chk("mr_req_rdy", 32'(req_rdy), 32'h1);
        tick();
        req_vld = '0;
        uart_cmd_rdy = 1'b1;
        tick();
        uart_cmd_rdy = 1'b0;
        tick();
        chk("mr_wait_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        uart_read_rdy = 1'b1;
        uart_read_data = 9'h1FF;
        tick();
        rst = 1'b0;
        uart_read_rdy = 1'b0;
        uart_read_data = '0;
        chk("mr_busy", 32'(busy), 32'h0);
        chk("mr_uart_cmd", 32'(uart_cmd), 32'h0);
        chk("mr_rsp_data", 32'(rsp_data), 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("mr_no_rsp", 32'(rsp_vld), 32'h0);
            tick();
        end
        uart_read_rdy = 1'b1;
        uart_read_data = 9'h1EE;
        tick();
        uart_read_rdy = 1'b0;
        uart_read_data = '0;
        tick();
        chk("stray_rsp_vld", 32'(rsp_vld), 32'h0);
        chk("stray_rsp_data", 32'(rsp_data), 32'h0);
        chk("stray_busy", 32'(busy), 32'h0);
        req_cmd[0*CW +: CW] = 16'h00A0;
        req_cmd[1*CW +: CW] = 16'h00B1;
        req_vld = 4'b0011;
        settle();
        chk("mr_grant0", 32'(req_rdy), 32'h1);
        tick();
        req_vld = '0;
        chk("mr_cmd0", 32'(uart_cmd), 32'h00A0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
